maxpool2x2_reader: RTL and testbench
====================================

Name: maxpool2x2_reader

Overview:
- Downstream consumer of the 28x28 8-bit image RAM (one write port, two read ports, 1-cycle registered read).
- On a start pulse, walks the stored image two rows at a time, using both read ports in parallel.
- Emits a 14x14 stream of 2x2 max-pooled pixels, with an index for each, to the feature/classifier stage.
- Raises done when all 196 pooled pixels have been emitted.

Parameters:
- IMG_W, 28, image width in pixels (even)
- IMG_H, 28, image height in pixels (even)
- DW, 8, pixel width (unsigned)
- AW, 10, RAM address width (must hold IMG_W*IMG_H-1)
- PW, 8, pooled-index width (must hold (IMG_W/2)*(IMG_H/2)-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to pool the stored image
- ram_busy  in  1  image writer active (RAM write enable asserted); blocks start
- addr_r1  out  AW  RAM read address, even row (2*pr)
- addr_r2  out  AW  RAM read address, odd row (2*pr+1)
- data_r1  in  DW  RAM read data for addr_r1, valid 1 cycle after address
- data_r2  in  DW  RAM read data for addr_r2, valid 1 cycle after address
- busy  out  1  high from start acceptance until done is asserted
- pool_valid  out  1  one-cycle strobe: pool_data/pool_idx valid
- pool_data  out  DW  max of the 2x2 block
- pool_idx  out  PW  pooled pixel index pr*(IMG_W/2)+pc, 0..195
- done  out  1  one-cycle pulse after the last pool_valid

Behaviour:
- Reset (rst=0, async): FSM to IDLE. addr_r1=0, addr_r2=0, busy=0, pool_valid=0, pool_data=0, pool_idx=0, done=0. All counters and hold registers cleared. Reset mid-scan aborts the scan; no done is generated.
- States: IDLE, RD_EVEN, RD_ODD, FLUSH, DONE.
- IDLE -> RD_EVEN at a clock edge where start=1 and ram_busy=0. Otherwise start is ignored, including while busy=1; requests are not queued.
- RD_EVEN:
  - addr_r1 = (2pr)*IMG_W + 2pc; addr_r2 = addr_r1 + IMG_W.
  - Next state RD_ODD.
- RD_ODD:
  - Addresses are the RD_EVEN addresses + 1 (column 2pc+1).
  - Then advance pc. At pc=IMG_W/2-1, wrap pc to 0 and increment pr.
  - Next state RD_EVEN, or FLUSH after the final block (pr=IMG_H/2-1, pc=IMG_W/2-1).
- Address generation is incremental (add 2, plus add IMG_W at row-pair wrap); no multiplier.
- Datapath pipeline:
  - In the cycle after an even-column issue: hold <= max(data_r1, data_r2).
  - In the cycle after the odd-column issue: pool_data <= max(hold, data_r1, data_r2) and pool_idx <= the block index; pool_valid=1 in the following cycle.
  - All comparisons unsigned. Ties are irrelevant to the result.
- FLUSH: waits for the final pipeline result (2 cycles), then goes to DONE.
- DONE: done=1 for one cycle, then IDLE; busy drops in the same cycle done is asserted.
- Timing, with start sampled at edge E0:
  - Cycle 1 issues block 0 even column; cycle 2 issues its odd column.
  - First pool_valid in cycle 4.
  - Subsequent pool_valid every 2 cycles.
  - Last valid (idx 195) in cycle 394; done in cycle 395.
  - Exactly 196 valid strobes per scan; pool_idx strictly increments 0..195.
- pool_valid is low in every cycle without a new result. pool_data and pool_idx hold their last values.
- Addresses hold their last value in IDLE. The block never issues an address >= IMG_W*IMG_H.
- ram_busy rising mid-scan is a system error: the scan continues, and results are unspecified.

Test Plan:
- Reset mid-scan: assert rst=0 at cycle 100 -> all outputs 0 immediately; no done. A new start after release gives a full 196-strobe scan.
- Ramp image, pic[a]=a mod 256, start -> pool_idx 0 has data 29 at cycle 4 and pool_idx 1 has data 31. A total of 196 strobes, done at cycle 395, busy high for cycles 1..394.
- Single hot pixel, all 0 except pic[57]=200 (row 2, col 1) -> only pool_idx 14 carries 200; all others 0.
- Corner max, pic[783]=255 and pic[0]=7, rest 0 -> idx 0 = 7, idx 195 = 255; addr_r2 max observed = 783, never higher.
- start with ram_busy=1 -> ignored (busy stays 0). start repeated while busy -> ignored; exactly one done.
- Back-to-back: start in the cycle after done -> accepted; the second scan timing is identical to the first.

Source files
------------

// File: rtl/maxpool2x2_reader.sv
// -----------------------------------------------------------------------------
// maxpool2x2_reader
//
// Reads a stored IMG_W x IMG_H image out of a dual-read-port RAM with a
// 1-cycle registered read. Two rows are read at once, one per port. The block
// emits a stream of 2x2 max-pooled pixels ((IMG_W/2) x (IMG_H/2) of them),
// each with its raster index, and then pulses done.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-low reset
//   start       single-cycle request to pool the stored image
//   ram_busy    image writer active; a start seen while it is high is ignored
//   addr_r1     RAM read address, even row of the current row pair
//   addr_r2     RAM read address, odd row of the current row pair
//   data_r1     RAM read data for addr_r1, valid 1 cycle after the address
//   data_r2     RAM read data for addr_r2, valid 1 cycle after the address
//   busy        high from start acceptance until done is asserted
//   pool_valid  one-cycle strobe: pool_data / pool_idx carry a new result
//   pool_data   max of the 2x2 block
//   pool_idx    pooled pixel index pr*(IMG_W/2)+pc
//   done        one-cycle pulse after the last pool_valid
// -----------------------------------------------------------------------------
module maxpool2x2_reader #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int PW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ram_busy,
    output logic [AW-1:0] addr_r1,
    output logic [AW-1:0] addr_r2,
    input  logic [DW-1:0] data_r1,
    input  logic [DW-1:0] data_r2,
    output logic          busy,
    output logic          pool_valid,
    output logic [DW-1:0] pool_data,
    output logic [PW-1:0] pool_idx,
    output logic          done
);

    localparam int CW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
    localparam int RW = (IMG_H / 2 > 1) ? $clog2(IMG_H / 2) : 1;

    localparam logic [CW-1:0] PC_LAST = CW'(IMG_W / 2 - 1);
    localparam logic [RW-1:0] PR_LAST = RW'(IMG_H / 2 - 1);
    localparam logic [CW-1:0] PC_ONE  = CW'(1);
    localparam logic [RW-1:0] PR_ONE  = RW'(1);
    localparam logic [PW-1:0] BLK_ONE = PW'(1);
    localparam logic [AW-1:0] A_ONE   = AW'(1);
    localparam logic [AW-1:0] A_W     = AW'(IMG_W);
    // From the odd column of the last block in a row pair, the next even-column
    // address is one column on plus the skipped odd row.
    localparam logic [AW-1:0] A_WRAP  = AW'(IMG_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_EVEN,
        RD_ODD,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] pc;
    logic [RW-1:0] pr;
    logic [PW-1:0] blk;        // index of the block being issued
    logic [PW-1:0] idx_q;      // index of the block whose odd column is in flight
    logic          ev_q;       // RAM data this cycle belongs to an even-column issue
    logic          od_q;       // RAM data this cycle belongs to an odd-column issue
    logic [DW-1:0] hold;       // max of the even column of the current block
    logic          flush_cnt;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DW-1:0] pair_max;
    assign pair_max = max2(data_r1, data_r2);

    // NOTE: every register here, state and datapath alike, is updated with
    // non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            pr         <= '0;
            blk        <= '0;
            idx_q      <= '0;
            ev_q       <= 1'b0;
            od_q       <= 1'b0;
            hold       <= '0;
            flush_cnt  <= 1'b0;
            addr_r1    <= '0;
            addr_r2    <= '0;
            busy       <= 1'b0;
            pool_valid <= 1'b0;
            pool_data  <= '0;
            pool_idx   <= '0;
            done       <= 1'b0;
        end else begin
            // Read-data tagging: the RAM returns data one cycle after the
            // address, so the state of the previous cycle says which column
            // the data on data_r1/data_r2 belongs to.
            ev_q <= (state == RD_EVEN);
            od_q <= (state == RD_ODD);

            if (ev_q) begin
                hold <= pair_max;
            end

            pool_valid <= od_q;
            if (od_q) begin
                pool_data <= max2(hold, pair_max);
                pool_idx  <= idx_q;
            end

            done <= 1'b0;

            // NOTE: the default branch keeps the encoding closed so unused
            // state codes fall back to IDLE instead of locking up.
            case (state)
                IDLE: begin
                    if (start && !ram_busy) begin
                        state   <= RD_EVEN;
                        busy    <= 1'b1;
                        pc      <= '0;
                        pr      <= '0;
                        blk     <= '0;
                        addr_r1 <= '0;
                        addr_r2 <= A_W;
                    end
                end

                RD_EVEN: begin
                    addr_r1 <= addr_r1 + A_ONE;
                    addr_r2 <= addr_r2 + A_ONE;
                    state   <= RD_ODD;
                end

                RD_ODD: begin
                    idx_q <= blk;
                    blk   <= blk + BLK_ONE;
                    if (pc == PC_LAST) begin
                        pc <= '0;
                        if (pr == PR_LAST) begin
                            // Last block: addresses stay on the final odd column.
                            state     <= FLUSH;
                            flush_cnt <= 1'b0;
                        end else begin
                            pr      <= pr + PR_ONE;
                            addr_r1 <= addr_r1 + A_WRAP;
                            addr_r2 <= addr_r2 + A_WRAP;
                            state   <= RD_EVEN;
                        end
                    end else begin
                        pc      <= pc + PC_ONE;
                        addr_r1 <= addr_r1 + A_ONE;
                        addr_r2 <= addr_r2 + A_ONE;
                        state   <= RD_EVEN;
                    end
                end

                FLUSH: begin
                    // Two cycles: the last read returns, then pool_valid shows.
                    if (flush_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2x2_reader.sv
// -----------------------------------------------------------------------------
// tb_maxpool2x2_reader
//
// Bench for maxpool2x2_reader. It contains a registered dual-read RAM model.
// Stimulus pushes the expected pooled stream into a scoreboard queue. A
// monitor pops one entry for each pool_valid and compares it. The stimulus
// side checks the directed timing, the boundary values, and the reset,
// ram_busy and restart cases.
// -----------------------------------------------------------------------------
module tb_maxpool2x2_reader;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int PW    = 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NBLK  = (IMG_W / 2) * (IMG_H / 2);

    logic          clk;
    logic          rst;
    logic          start;
    logic          ram_busy;
    logic [AW-1:0] addr_r1;
    logic [AW-1:0] addr_r2;
    logic [DW-1:0] data_r1;
    logic [DW-1:0] data_r2;
    logic          busy;
    logic          pool_valid;
    logic [DW-1:0] pool_data;
    logic [PW-1:0] pool_idx;
    logic          done;

    maxpool2x2_reader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW), .PW(PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram_busy  (ram_busy),
        .addr_r1   (addr_r1),
        .addr_r2   (addr_r2),
        .data_r1   (data_r1),
        .data_r2   (data_r2),
        .busy      (busy),
        .pool_valid(pool_valid),
        .pool_data (pool_data),
        .pool_idx  (pool_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image RAM: full address space, 1-cycle registered read on both ports.
    logic [DW-1:0] pic [1024];
    always_ff @(posedge clk) begin
        data_r1 <= pic[addr_r1];
        data_r2 <= pic[addr_r2];
    end

    typedef struct packed {
        logic [PW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   got[NBLK];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst === 1'b1 && pool_valid === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_pool_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pool_idx", 32'(pool_idx), 32'(e.idx));
                check("pool_data", 32'(pool_data), 32'(e.data));
            end
            if (int'(pool_idx) < NBLK) got[pool_idx] = int'(pool_data);
        end
    end

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic push_expected();
        for (int pr = 0; pr < IMG_H / 2; pr++) begin
            for (int pc = 0; pc < IMG_W / 2; pc++) begin
                int a;
                exp_t e;
                a      = 2 * pr * IMG_W + 2 * pc;
                e.idx  = PW'(pr * (IMG_W / 2) + pc);
                e.data = mx(mx(pic[a], pic[a+1]), mx(pic[a+IMG_W], pic[a+IMG_W+1]));
                sb.push_back(e);
            end
        end
    endtask

    task automatic clear_pic();
        for (int a = 0; a < 1024; a++) pic[a] = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr_r1"}, 32'(addr_r1), 32'd0);
        check({tag, "_addr_r2"}, 32'(addr_r2), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pool_valid"}, 32'(pool_valid), 32'd0);
        check({tag, "_pool_data"}, 32'(pool_data), 32'd0);
        check({tag, "_pool_idx"}, 32'(pool_idx), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // One scan: start pulse just after a rising edge; that edge is E0.
    // Cycle k is sampled on the k-th falling edge after E0. The task returns
    // on the falling edge of the done cycle, or after the cycle budget.
    task automatic run_scan(input string tag, input bit spam);
        int first_v, last_v, nvalid, busy_err, addr_err, max_a2, done_cyc;
        first_v = -1; last_v = -1; nvalid = 0; busy_err = 0;
        addr_err = 0; max_a2 = 0; done_cyc = -1;
        for (int i = 0; i < NBLK; i++) got[i] = -1;
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (pool_valid === 1'b1) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                nvalid++;
            end
            if (busy !== (k <= 394)) busy_err++;
            if (int'(addr_r1) >= NPIX || int'(addr_r2) >= NPIX) addr_err++;
            if (int'(addr_r2) > max_a2) max_a2 = int'(addr_r2);
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            start = spam && (k == 50 || k == 200);
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'd395);
        check({tag, "_first_valid_cycle"}, 32'(first_v), 32'd4);
        check({tag, "_last_valid_cycle"}, 32'(last_v), 32'd394);
        check({tag, "_valid_count"}, 32'(nvalid), 32'd196);
        check({tag, "_busy_window_errors"}, 32'(busy_err), 32'd0);
        check({tag, "_addr_out_of_range"}, 32'(addr_err), 32'd0);
        check({tag, "_addr_r2_max"}, 32'(max_a2), 32'd783);
        check({tag, "_idx_held_at_done"}, 32'(pool_idx), 32'd195);
        check({tag, "_scoreboard_left"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; ram_busy = 1'b0;
        clear_pic();
        #3 rst = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // start while the image writer is active must be ignored.
        ram_busy = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt++;
        end
        check("ram_busy_start_ignored", 32'(cnt), 32'd0);
        ram_busy = 1'b0;

        // Ramp image.
        for (int a = 0; a < NPIX; a++) pic[a] = DW'(a);

        // Reset in the middle of a scan: outputs clear at once, no done follows.
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("midscan_reset");
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (450) begin
            @(negedge clk);
            if (done === 1'b1 || pool_valid === 1'b1) cnt++;
        end
        check("no_output_after_abort", 32'(cnt), 32'd0);

        // Full ramp scan with start pulses repeated while busy.
        run_scan("ramp", 1'b1);
        check("ramp_idx0", 32'(got[0]), 32'd29);
        check("ramp_idx1", 32'(got[1]), 32'd31);
        check("ramp_idx195", 32'(got[195]), 32'd243);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("ramp_single_done", 32'(cnt), 32'd0);

        // Single hot pixel at row 2, col 1.
        clear_pic();
        pic[57] = 8'd200;
        run_scan("hot", 1'b0);
        check("hot_idx14", 32'(got[14]), 32'd200);
        cnt = 0;
        for (int i = 0; i < NBLK; i++) if (i != 14 && got[i] != 0) cnt++;
        check("hot_others_zero", 32'(cnt), 32'd0);

        // Corner maxima, started in the cycle after the previous done.
        clear_pic();
        pic[0]   = 8'd7;
        pic[783] = 8'd255;
        run_scan("corner_b2b", 1'b0);
        check("corner_idx0", 32'(got[0]), 32'd7);
        check("corner_idx195", 32'(got[195]), 32'd255);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
